// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// operation encodings, FSM states and the EX ALU opcodes it drives.
package muldiv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  typedef enum logic [2:0] {
    MD_MUL  = 3'b000,
    MD_DIVU = 3'b001,
    MD_REMU = 3'b010,
    MD_DIV  = 3'b011,
    MD_REM  = 3'b100
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE_A = 3'd1,
    S_PRE_B = 3'd2,
    S_ITER  = 3'd3,
    S_POST  = 3'd4,
    S_DONE  = 3'd5
  } md_state_e;

  // Remainder-type operations return the partial remainder instead of the quotient.
  function automatic logic op_is_rem(input logic [2:0] op);
    return (op == 3'(MD_REMU)) || (op == 3'(MD_REM));
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Pipeline/ALU-side bundle of the multiply/divide sequencer.
interface muldiv_seq_if;
  import muldiv_pkg::*;

  logic            Start;
  logic [2:0]      MdOp;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic            Flush;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] Result;
  logic            Illegal;
  logic            AluSel;
  logic [XLEN-1:0] AluSrcA;
  logic [XLEN-1:0] AluSrcB;
  logic [3:0]      AluControl;
  logic [XLEN-1:0] AluResult;

  modport master (
    output Start, MdOp, SrcA, SrcB, Flush, AluResult,
    input  Busy, Done, Result, Illegal, AluSel, AluSrcA, AluSrcB, AluControl
  );

  modport slave (
    input  Start, MdOp, SrcA, SrcB, Flush, AluResult,
    output Busy, Done, Result, Illegal, AluSel, AluSrcA, AluSrcB, AluControl
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MUL/DIVU/REMU sequencer sharing the EX ALU, one add/sub per cycle.
// Define MULDIV_SIGNED_EN to add signed DIV/REM (PRE_A/PRE_B/POST states).
module muldiv_seq
  import muldiv_pkg::*;
(
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_acc;     // product accumulator / partial remainder
  logic [XLEN-1:0]  r_a;       // multiplicand / dividend-then-quotient
  logic [XLEN-1:0]  r_b;       // multiplier / divisor
  logic [2:0]       r_op;
  logic [XLEN-1:0]  r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_illegal;
`ifdef MULDIV_SIGNED_EN
  logic             r_sign_q;
  logic             r_sign_r;
`endif

  logic            w_legal;
  logic            w_div0;
  logic            w_start_signed;
  logic            w_op_signed;
  logic            w_is_mul;
  logic [XLEN:0]   w_r33;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_iter_res;
  logic            w_alu_sel;
  logic [XLEN-1:0] w_alu_a;
  logic [XLEN-1:0] w_alu_b;
  logic [3:0]      w_alu_ctl;

`ifdef MULDIV_SIGNED_EN
  assign w_legal        = bus.MdOp <= 3'(MD_REM);
  assign w_start_signed = (bus.MdOp == 3'(MD_DIV)) || (bus.MdOp == 3'(MD_REM));
  assign w_op_signed    = (r_op == 3'(MD_DIV)) || (r_op == 3'(MD_REM));
`else
  assign w_legal        = bus.MdOp <= 3'(MD_REMU);
  assign w_start_signed = 1'b0;
  assign w_op_signed    = 1'b0;
`endif

  assign w_div0   = (bus.MdOp != 3'(MD_MUL)) && (bus.SrcB == '0);
  assign w_is_mul = r_op == 3'(MD_MUL);

  // Restoring-division step; the 33rd bit makes the compare exact.
  assign w_r33      = {r_acc, r_a[XLEN-1]};
  assign w_ge       = w_r33[XLEN] | (w_r33[XLEN-1:0] >= r_b);
  assign w_rem_nxt  = w_ge ? bus.AluResult : w_r33[XLEN-1:0];
  assign w_quo_nxt  = {r_a[XLEN-2:0], w_ge};
  assign w_iter_res = w_is_mul ? bus.AluResult : (op_is_rem(r_op) ? w_rem_nxt : w_quo_nxt);

  // Operand steering into the shared EX ALU.
  always_comb begin
    w_alu_sel = 1'b0;
    w_alu_a   = '0;
    w_alu_b   = '0;
    w_alu_ctl = ALU_ADD;
    case (r_state)
      S_ITER: begin
        w_alu_sel = 1'b1;
        if (w_is_mul) begin
          w_alu_a = r_acc;
          w_alu_b = r_b[0] ? r_a : '0;
        end else begin
          w_alu_a   = w_r33[XLEN-1:0];
          w_alu_b   = r_b;
          w_alu_ctl = ALU_SUB;
        end
      end
`ifdef MULDIV_SIGNED_EN
      S_PRE_A: begin
        w_alu_sel = 1'b1;
        w_alu_b   = r_a;
        w_alu_ctl = ALU_SUB;
      end
      S_PRE_B: begin
        w_alu_sel = 1'b1;
        w_alu_b   = r_b;
        w_alu_ctl = ALU_SUB;
      end
      S_POST: begin
        w_alu_sel = 1'b1;
        w_alu_b   = op_is_rem(r_op) ? r_acc : r_a;
        w_alu_ctl = ALU_SUB;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
`endif
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      if (r_state != S_IDLE && bus.Flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.Start) begin
              if (!w_legal) begin
                r_illegal <= 1'b1;
              end else begin
                r_op   <= bus.MdOp;
                r_a    <= bus.SrcA;
                r_b    <= bus.SrcB;
                r_acc  <= '0;
                r_cnt  <= CNT_W'(XLEN - 1);
                r_busy <= 1'b1;
                if (w_div0) begin
                  r_state  <= S_DONE;
                  r_done   <= 1'b1;
                  r_result <= op_is_rem(bus.MdOp) ? bus.SrcA : '1;
                end else if (w_start_signed) begin
                  r_state <= S_PRE_A;
                end else begin
                  r_state <= S_ITER;
                end
              end
            end
          end
          S_ITER: begin
            if (w_is_mul) begin
              r_acc <= bus.AluResult;
              r_a   <= r_a << 1;
              r_b   <= r_b >> 1;
            end else begin
              r_acc <= w_rem_nxt;
              r_a   <= w_quo_nxt;
            end
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_cnt == '0) begin
              if (w_op_signed) begin
                r_state <= S_POST;
              end else begin
                r_state  <= S_DONE;
                r_done   <= 1'b1;
                r_result <= w_iter_res;
              end
            end
          end
`ifdef MULDIV_SIGNED_EN
          S_PRE_A: begin
            if (r_a[XLEN-1]) r_a <= bus.AluResult;
            r_sign_r <= r_a[XLEN-1];
            r_state  <= S_PRE_B;
          end
          S_PRE_B: begin
            if (r_b[XLEN-1]) r_b <= bus.AluResult;
            r_sign_q <= r_sign_r ^ r_b[XLEN-1];
            r_state  <= S_ITER;
          end
          S_POST: begin
            if (op_is_rem(r_op)) r_result <= r_sign_r ? bus.AluResult : r_acc;
            else                 r_result <= r_sign_q ? bus.AluResult : r_a;
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
`endif
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Busy       = r_busy;
  assign bus.Done       = r_done;
  assign bus.Result     = r_result;
  assign bus.Illegal    = r_illegal;
  assign bus.AluSel     = w_alu_sel;
  assign bus.AluSrcA    = w_alu_a;
  assign bus.AluSrcB    = w_alu_b;
  assign bus.AluControl = w_alu_ctl;

endmodule
